// File: rtl/tiny_dnn_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tiny_dnn_seq
//  Description : Sequencer for one dot-product (neuron) evaluation on a
//                tiny_dnn_core plus its normalize stage. One start pulse
//                runs the whole sequence: init, a stream of exec cycles over
//                feature addresses 0..n-1, an optional bias term, a pipeline
//                drain, update, normalize enable and capture of the float32
//                result. The result is then held on a valid/ready output.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1   clock
//    reset      in   1   synchronous active-high reset
//    start      in   1   begin one evaluation (sampled in IDLE only)
//    fsize      in   AW  number of feature terms n (clamped to F_SIZE-2)
//    use_bias   in   1   add the bias term (sampled with start)
//    busy       out  1   high in every state except IDLE
//    init       out  1   core init
//    exec       out  1   core exec
//    bias       out  1   core bias
//    update     out  1   core update
//    ra         out  AW  core / feature RAM read address
//    norm_en    out  1   normalize enable
//    nrm        in   32  normalized float32 from normalize
//    out_valid  out  1   result valid
//    out_ready  in   1   result accepted
//    result     out  32  captured float32 result
// ============================================================================
module tiny_dnn_seq #(
    parameter int F_SIZE = 1024,
    parameter int AW     = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] fsize,
    input  logic          use_bias,
    output logic          busy,
    output logic          init,
    output logic          exec,
    output logic          bias,
    output logic          update,
    output logic [AW-1:0] ra,
    output logic          norm_en,
    input  logic [31:0]   nrm,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   result
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_INIT   = 4'd1,
        S_EXEC   = 4'd2,
        S_BIAS   = 4'd3,
        S_DRAIN  = 4'd4,
        S_UPDATE = 4'd5,
        S_NORM   = 4'd6,
        S_CAPT   = 4'd7,
        S_DONE   = 4'd8
    } state_t;

    // Largest usable term count: the top RAM slot belongs to the bias weight,
    // so the feature stream must stop short of it.
    localparam logic [AW:0] C_N_MAX    = (AW+1)'(F_SIZE - 2);
    localparam logic [AW:0] C_CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0] C_CNT_ZERO = '0;
    localparam logic [AW-1:0] C_RA_ONE = AW'(1);

    state_t      r_state;
    logic [AW:0] r_n;        // latched term count (one bit wider: no wrap)
    logic        r_b;        // latched bias request
    logic [AW:0] r_cnt;      // exec address counter / drain cycle counter

    logic [AW:0] w_fsize_ext;
    logic [AW:0] w_n_clamped;
    logic [AW:0] w_cnt_next;

    assign w_fsize_ext = {1'b0, fsize};
    assign w_n_clamped = (w_fsize_ext > C_N_MAX) ? C_N_MAX : w_fsize_ext;
    assign w_cnt_next  = r_cnt + C_CNT_ONE;

    // All control outputs are registered and set together with the state
    // they belong to, so each pulse lines up exactly with its state cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_n       <= '0;
            r_b       <= 1'b0;
            r_cnt     <= '0;
            busy      <= 1'b0;
            init      <= 1'b0;
            exec      <= 1'b0;
            bias      <= 1'b0;
            update    <= 1'b0;
            norm_en   <= 1'b0;
            ra        <= '0;
            out_valid <= 1'b0;
            result    <= '0;
        end else begin
            // One-cycle pulses default low; each state raises what it needs
            // for the following cycle.
            init    <= 1'b0;
            exec    <= 1'b0;
            bias    <= 1'b0;
            update  <= 1'b0;
            norm_en <= 1'b0;
            ra      <= '0;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_n     <= w_n_clamped;
                        r_b     <= use_bias;
                        r_state <= S_INIT;
                        init    <= 1'b1;
                        busy    <= 1'b1;
                    end
                end

                S_INIT: begin
                    r_cnt <= C_CNT_ZERO;
                    if (r_n != C_CNT_ZERO) begin
                        r_state <= S_EXEC;
                        exec    <= 1'b1;
                        ra      <= '0;
                    end else if (r_b) begin
                        r_state <= S_BIAS;
                        bias    <= 1'b1;
                    end else begin
                        r_state <= S_DRAIN;
                    end
                end

                S_EXEC: begin
                    // r_cnt holds the address being issued this cycle.
                    if (w_cnt_next == r_n) begin
                        r_cnt <= C_CNT_ZERO;
                        if (r_b) begin
                            r_state <= S_BIAS;
                            bias    <= 1'b1;
                        end else begin
                            r_state <= S_DRAIN;
                        end
                    end else begin
                        r_cnt <= w_cnt_next;
                        exec  <= 1'b1;
                        ra    <= r_cnt[AW-1:0] + C_RA_ONE;
                    end
                end

                S_BIAS: begin
                    // The core substitutes the bias address and d=1.0 itself.
                    r_cnt   <= C_CNT_ZERO;
                    r_state <= S_DRAIN;
                end

                S_DRAIN: begin
                    // Two idle cycles let the last term leave the 2-deep
                    // core pipeline before the accumulator is copied out.
                    if (r_cnt == C_CNT_ONE) begin
                        r_cnt   <= C_CNT_ZERO;
                        r_state <= S_UPDATE;
                        update  <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_next;
                    end
                end

                S_UPDATE: begin
                    r_state <= S_NORM;
                    norm_en <= 1'b1;
                end

                S_NORM: begin
                    r_state <= S_CAPT;
                end

                S_CAPT: begin
                    result    <= nrm;
                    out_valid <= 1'b1;
                    r_state   <= S_DONE;
                end

                S_DONE: begin
                    // start is deliberately not looked at here; a start held
                    // with out_ready is taken in the following IDLE cycle.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end

                default: begin
                    r_state   <= S_IDLE;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tiny_dnn_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tiny_dnn_seq
//  Description : Self-checking bench for tiny_dnn_seq. A behavioural core /
//                normalize stand-in produces nrm from the pulses it sees; a
//                timeline model predicts every output cycle by cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tiny_dnn_seq;

    localparam int F_SIZE = 1024;
    localparam int AW     = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] fsize;
    logic          use_bias;
    logic          busy;
    logic          init;
    logic          exec;
    logic          bias;
    logic          update;
    logic [AW-1:0] ra;
    logic          norm_en;
    logic [31:0]   nrm = '0;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   result;

    always #5 clk = ~clk;

    tiny_dnn_seq #(.F_SIZE(F_SIZE), .AW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .fsize     (fsize),
        .use_bias  (use_bias),
        .busy      (busy),
        .init      (init),
        .exec      (exec),
        .bias      (bias),
        .update    (update),
        .ra        (ra),
        .norm_en   (norm_en),
        .nrm       (nrm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    // bfloat16 feature and weight memories
    logic [15:0] fmem [F_SIZE];
    logic [15:0] wmem [F_SIZE];

    function automatic real bf2real(input logic [15:0] b);
        real v;
        int  e;
        if (b[14:7] == 8'd0) return 0.0;
        v = 1.0 + real'(b[6:0]) / 128.0;
        e = int'(b[14:7]) - 127;
        while (e > 0) begin v = v * 2.0; e--; end
        while (e < 0) begin v = v / 2.0; e++; end
        return b[15] ? -v : v;
    endfunction

    function automatic logic [31:0] real2f32(input real x);
        real         a;
        int          e;
        longint      m;
        logic [31:0] r;
        if (x == 0.0) return 32'h0;
        a = (x < 0.0) ? -x : x;
        e = 0;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0)  begin a = a * 2.0; e--; end
        m = longint'((a - 1.0) * 8388608.0);
        r[31]    = (x < 0.0);
        r[30:23] = 8'(e + 127);
        r[22:0]  = m[22:0];
        return r;
    endfunction

    // ---------------- core + normalize stand-in ----------------
    real acc  = 0.0;
    real held = 0.0;
    always @(posedge clk) begin
        if (init)
            acc = 0.0;
        else if (exec)
            acc = acc + bf2real(fmem[ra]) * bf2real(wmem[ra]);
        else if (bias)
            acc = acc + bf2real(wmem[F_SIZE-1]);
        if (update)  held = acc;
        if (norm_en) nrm <= real2f32(held);
    end

    // ---------------- timeline reference model ----------------
    bit          m_act = 1'b0;
    int          m_rel = 0;
    int          m_n   = 0;
    int          m_b   = 0;
    logic [31:0] m_res = '0;
    logic [31:0] m_pend = '0;

    function automatic logic [31:0] dot_expected(input int n, input int b);
        real s;
        s = 0.0;
        for (int k = 0; k < n; k++) s = s + bf2real(fmem[k]) * bf2real(wmem[k]);
        if (b != 0) s = s + bf2real(wmem[F_SIZE-1]);
        return real2f32(s);
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_act = 1'b0;
            m_rel = 0;
            m_res = '0;
        end else if (!m_act) begin
            if (start) begin
                m_act  = 1'b1;
                m_rel  = 1;
                m_n    = (int'(fsize) > F_SIZE - 2) ? F_SIZE - 2 : int'(fsize);
                m_b    = use_bias ? 1 : 0;
                m_pend = dot_expected(m_n, m_b);
            end
        end else if (m_rel >= m_n + m_b + 7 && out_ready) begin
            m_act = 1'b0;
        end else begin
            m_rel++;
            if (m_rel == m_n + m_b + 7) m_res = m_pend;
        end
    end

    // ---------------- checking ----------------
    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy",    32'(busy),    32'(m_act));
            check("init",    32'(init),    32'(m_act && m_rel == 1));
            check("exec",    32'(exec),    32'(m_act && m_rel >= 2 && m_rel <= m_n + 1));
            check("ra",      32'(ra),      (m_act && m_rel >= 2 && m_rel <= m_n + 1) ? 32'(m_rel - 2) : 32'h0);
            check("bias",    32'(bias),    32'(m_act && m_b == 1 && m_rel == m_n + 2));
            check("update",  32'(update),  32'(m_act && m_rel == m_n + m_b + 4));
            check("norm_en", 32'(norm_en), 32'(m_act && m_rel == m_n + m_b + 5));
            check("valid",   32'(out_valid), 32'(m_act && m_rel >= m_n + m_b + 7));
            check("result",  result,       m_res);
        end
    end

    // One evaluation with a single start pulse; returns in the first cycle
    // out_valid is seen (or at the bound). Cycle 1 is the init cycle.
    task automatic run(input int n, input bit b, input logic [31:0] exp_res,
                       input int exp_lat, input int exp_exec);
        int cyc;
        int n_exec;
        int n_bias;
        @(negedge clk);
        start    = 1'b1;
        fsize    = n[AW-1:0];
        use_bias = b;
        @(negedge clk);
        start  = 1'b0;
        cyc    = 1;
        n_exec = 0;
        n_bias = 0;
        while (!out_valid && cyc < 3000) begin
            if (exec) n_exec++;
            if (bias) n_bias++;
            @(negedge clk);
            cyc++;
        end
        check("latency",   32'(cyc),    32'(exp_lat));
        check("lit_res",   result,      exp_res);
        check("exec_cnt",  32'(n_exec), 32'(exp_exec));
        check("bias_cnt",  32'(n_bias), 32'(b));
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("idle_after_accept", 32'(busy), 32'h0);
    endtask

    int n_init;

    initial begin
        for (int i = 0; i < F_SIZE; i++) begin
            fmem[i] = 16'h3F80;
            wmem[i] = 16'h3F80;
        end
        reset     = 1'b1;
        start     = 1'b0;
        fsize     = '0;
        use_bias  = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("rst_busy",   32'(busy),      32'h0);
        check("rst_valid",  32'(out_valid), 32'h0);
        check("rst_result", result,         32'h0);
        reset = 1'b0;

        // 4 x (1.0*1.0) = 4.0, then hold the result with start pokes
        run(4, 1'b0, 32'h4080_0000, 11, 4);
        for (int i = 0; i < 5; i++) begin
            start = i[0];
            @(negedge clk);
            check("hold_valid",  32'(out_valid), 32'h1);
            check("hold_result", result,         32'h4080_0000);
        end
        start = 1'b0;
        release_result();

        // 4.0 + bias weight 2.0 = 6.0
        wmem[F_SIZE-1] = 16'h4000;
        run(4, 1'b1, 32'h40C0_0000, 12, 4);
        release_result();

        // empty evaluation: cleared accumulator
        run(0, 1'b0, 32'h0, 7, 0);
        release_result();

        // reset in the middle of a long exec stream
        @(negedge clk);
        start = 1'b1;
        fsize = AW'(8);
        use_bias = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_exec", 32'(exec), 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        reset = 1'b0;
        wmem[0] = 16'h4040;
        wmem[1] = 16'h4040;
        run(2, 1'b0, 32'h40C0_0000, 9, 2);
        release_result();
        wmem[0] = 16'h3F80;
        wmem[1] = 16'h3F80;

        // oversized fsize clamps to 1022 terms; plus bias 2.0 = 1024.0
        run(1023, 1'b1, 32'h4480_0000, 1030, 1022);
        release_result();

        // negative features, start and out_ready held high
        fmem[0] = 16'hBF80;
        fmem[1] = 16'hBF80;
        fmem[2] = 16'hBF80;
        @(negedge clk);
        start     = 1'b1;
        fsize     = AW'(3);
        use_bias  = 1'b0;
        out_ready = 1'b1;
        n_init    = 0;
        for (int i = 0; i < 33; i++) begin
            @(negedge clk);
            if (init) n_init++;
        end
        start = 1'b0;
        for (int i = 0; i < 40 && busy; i++) @(negedge clk);
        out_ready = 1'b0;
        check("held_start_inits", 32'(n_init), 32'd3);
        check("neg_result",       result,      32'hC040_0000);
        check("final_idle",       32'(busy),   32'h0);

        @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
